// File: rtl/count_pkg.sv
// Shared types for the counter capture path: entry tags, capture FSM states,
// the entry layout and the tag classifier used when a counter value changes.
// No ports; imported by count_capture_buf and count_sync_fifo.
package count_pkg;

    typedef enum logic [1:0] {
        TAG_STEP    = 2'b00,
        TAG_LOAD    = 2'b01,
        TAG_WRAP_UP = 2'b10,
        TAG_WRAP_DN = 2'b11
    } tag_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_e;

    // Entry layout at the default counter width. The top re-declares the same
    // {tag, value} layout at its own WIDTH parameter.
    localparam int unsigned ENTRY_VAL_W = 4;

    typedef struct packed {
        tag_e                   tag;
        logic [ENTRY_VAL_W-1:0] value;
    } entry_t;

    // Tag priority: load beats wrap detection, wrap beats a plain step.
    // Kept width-agnostic by taking the range comparisons as flags.
    function automatic tag_e classify_tag(
        input logic load,
        input logic up,
        input logic prev_is_max,
        input logic prev_is_zero,
        input logic cur_is_max,
        input logic cur_is_zero
    );
        if (load)
            return TAG_LOAD;
        else if (prev_is_max && cur_is_zero && up)
            return TAG_WRAP_UP;
        else if (prev_is_zero && cur_is_max && !up)
            return TAG_WRAP_DN;
        else
            return TAG_STEP;
    endfunction

endpackage

// File: rtl/count_sync_fifo.sv
// Generic DEPTH x DW synchronous FIFO with registered read data and a
// 1-cycle rd_valid pulse. Owns pointers, level, full/empty and a sticky
// overflow flag. A pop frees the slot a same-cycle push needs when full.
// Ports: clock/resetn, clear (sync flush), wr_en/wr_data, rd_en ->
// rd_data/rd_valid, full, empty, level, overflow.
module count_sync_fifo
    import count_pkg::*;
#(
    parameter int DW    = 6,
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     clear,
    input  logic                     wr_en,
    input  logic [DW-1:0]            wr_data,
    input  logic                     rd_en,
    output logic [DW-1:0]            rd_data,
    output logic                     rd_valid,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [DW-1:0] rd_data_q, rd_data_d;
    logic          rd_valid_q, rd_valid_d;
    logic          overflow_q, overflow_d;
    logic          pop_ok;
    logic          push_ok;

    assign full  = (level_q == LW'(DEPTH));
    assign empty = (level_q == '0);

    // A pop is only possible with data present; a push also fits when full
    // provided the same-cycle pop frees a slot.
    assign pop_ok  = rd_en && !empty;
    assign push_ok = wr_en && (!full || pop_ok);

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        overflow_d = overflow_q;

        if (clear) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = '0;
            rd_data_d  = '0;
            overflow_d = 1'b0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = wr_data;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                // Reads the pre-edge contents, so a full push+pop on the
                // same slot returns the oldest entry, not the new one.
                rd_data_d  = mem_q[rd_ptr_q];
                rd_valid_d = 1'b1;
                rd_ptr_d   = rd_ptr_q + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
            if (wr_en && !push_ok)
                overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            overflow_q <= overflow_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign level    = level_q;
    assign overflow = overflow_q;

endmodule

// File: rtl/count_capture_buf.sv
// Watches a mod-MODULO up/down counter and records every value change as a
// tagged {tag, value} entry into a FIFO drained through rd_en/rd_valid.
// Ports: clock/resetn, counter taps (cnt_in, cnt_load, cnt_up_down),
// cap_en, clear, rd_en -> rd_data, rd_valid, full, empty, level, overflow.
module count_capture_buf
    import count_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int MODULO = 12,
    parameter int DEPTH  = 8
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic [WIDTH-1:0]       cnt_in,
    input  logic                   cnt_load,
    input  logic                   cnt_up_down,
    input  logic                   cap_en,
    input  logic                   clear,
    input  logic                   rd_en,
    output logic [WIDTH+1:0]       rd_data,
    output logic                   rd_valid,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow
);

    typedef struct packed {
        tag_e             tag;
        logic [WIDTH-1:0] value;
    } cap_entry_t;

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULO - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic             push;
    tag_e             push_tag;
    cap_entry_t       push_entry;

    always_comb begin
        state_d  = state_q;
        prev_d   = prev_q;
        push     = 1'b0;
        push_tag = TAG_STEP;

        if (clear) begin
            state_d = IDLE;
            prev_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cap_en)
                        state_d = PRIME;
                end
                PRIME: begin
                    // Baseline entry so the history starts from a known value.
                    push     = 1'b1;
                    push_tag = TAG_LOAD;
                    prev_d   = cnt_in;
                    state_d  = RUN;
                end
                RUN: begin
                    if (!cap_en) begin
                        state_d = IDLE;
                    end else begin
                        push     = cnt_load || (cnt_in != prev_q);
                        push_tag = classify_tag(cnt_load, cnt_up_down,
                                                prev_q == MAX_VAL, prev_q == '0,
                                                cnt_in == MAX_VAL, cnt_in == '0);
                        prev_d   = cnt_in;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        push_entry.tag   = push_tag;
        push_entry.value = cnt_in;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            prev_q  <= '0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
        end
    end

    count_sync_fifo #(
        .DW    (WIDTH + 2),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock    (clock),
        .resetn   (resetn),
        .clear    (clear),
        .wr_en    (push),
        .wr_data  (push_entry),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .overflow (overflow)
    );

endmodule

// File: tb/tb_count_capture_buf.sv
// Bench for count_capture_buf: directed scenarios followed by randomized
// counter-like stimulus, all checked against a queue-based reference model.
// Ports: none (top-level bench).
module tb_count_capture_buf;

    localparam int WIDTH  = 4;
    localparam int MODULO = 12;
    localparam int DEPTH  = 8;

    logic             clock = 1'b0;
    logic             resetn;
    logic [WIDTH-1:0] cnt_in;
    logic             cnt_load;
    logic             cnt_up_down;
    logic             cap_en;
    logic             clear;
    logic             rd_en;
    logic [WIDTH+1:0] rd_data;
    logic             rd_valid;
    logic             full;
    logic             empty;
    logic [3:0]       level;
    logic             overflow;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: entry history as a queue, capture mode as an int.
    int mq[$];
    int m_mode;   // 0 = not capturing, 1 = baseline due, 2 = capturing
    int m_prev;
    bit m_ovf;
    int m_rd;
    bit m_rv;

    always #5 clock = ~clock;

    count_capture_buf #(
        .WIDTH  (WIDTH),
        .MODULO (MODULO),
        .DEPTH  (DEPTH)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .cnt_in      (cnt_in),
        .cnt_load    (cnt_load),
        .cnt_up_down (cnt_up_down),
        .cap_en      (cap_en),
        .clear       (clear),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .full        (full),
        .empty       (empty),
        .level       (level),
        .overflow    (overflow)
    );

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_mode = 0;
        m_prev = 0;
        m_ovf  = 1'b0;
        m_rd   = 0;
        m_rv   = 1'b0;
    endtask

    task automatic model_edge();
        int  cnt;
        int  tag;
        bit  do_push;
        int  entry;
        cnt     = int'(cnt_in);
        do_push = 1'b0;
        entry   = 0;
        if (clear) begin
            model_clear();
            return;
        end
        if (m_mode == 0) begin
            if (cap_en) m_mode = 1;
        end else if (m_mode == 1) begin
            do_push = 1'b1;
            entry   = 16 + cnt;
            m_prev  = cnt;
            m_mode  = 2;
        end else begin
            if (!cap_en) begin
                m_mode = 0;
            end else begin
                if (cnt_load)
                    tag = 1;
                else if (m_prev == MODULO - 1 && cnt == 0 && cnt_up_down)
                    tag = 2;
                else if (m_prev == 0 && cnt == MODULO - 1 && !cnt_up_down)
                    tag = 3;
                else
                    tag = 0;
                do_push = cnt_load || (cnt != m_prev);
                entry   = tag * 16 + cnt;
                m_prev  = cnt;
            end
        end
        // Pop sees the pre-edge queue; a push then fits if a slot is free.
        m_rv = 1'b0;
        if (rd_en && mq.size() > 0) begin
            m_rd = mq.pop_front();
            m_rv = 1'b1;
        end
        if (do_push) begin
            if (mq.size() < DEPTH) mq.push_back(entry);
            else                   m_ovf = 1'b1;
        end
    endtask

    task automatic check_all();
        check("level",    32'(level),    32'(mq.size()));
        check("full",     32'(full),     32'(mq.size() == DEPTH));
        check("empty",    32'(empty),    32'(mq.size() == 0));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("rd_valid", 32'(rd_valid), 32'(m_rv));
        check("rd_data",  32'(rd_data),  32'(m_rd));
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic pop_expect(input int exp);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        check("pop_valid", 32'(rd_valid), 32'd1);
        check("pop_data",  32'(rd_data),  32'(exp));
    endtask

    initial begin
        int up_vals[4];
        int dn_vals[4];
        int ov_vals[10];
        int ov_exp[8];
        int fill_vals[7];
        int gc;
        bit gdir;
        int r;

        up_vals   = '{10, 11, 0, 1};
        dn_vals   = '{2, 1, 0, 11};
        ov_vals   = '{8, 9, 10, 11, 0, 1, 2, 3, 4, 5};
        ov_exp    = '{8'h08, 8'h09, 8'h0A, 8'h0B, 8'h20, 8'h01, 8'h02, 8'h03};
        fill_vals = '{6, 7, 8, 9, 10, 11, 0};

        resetn      = 1'b0;
        cnt_in      = '0;
        cnt_load    = 1'b0;
        cnt_up_down = 1'b1;
        cap_en      = 1'b0;
        clear       = 1'b0;
        rd_en       = 1'b0;
        model_clear();
        #12;
        check("rst_level",    32'(level),    32'd0);
        check("rst_empty",    32'(empty),    32'd1);
        check("rst_full",     32'(full),     32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_rd_data",  32'(rd_data),  32'd0);
        @(posedge clock);
        #1 resetn = 1'b1;

        // Baseline entry on capture start.
        cnt_in = 4'd5;
        cap_en = 1'b1;
        step();
        step();
        check("prime_level", 32'(level), 32'd1);
        pop_expect(8'h15);

        // Up count through the wrap.
        cnt_up_down = 1'b1;
        foreach (up_vals[i]) begin
            cnt_in = 4'(up_vals[i]);
            step();
        end
        pop_expect(8'h0A);
        pop_expect(8'h0B);
        pop_expect(8'h20);
        pop_expect(8'h01);

        // Down count through the wrap.
        cnt_up_down = 1'b0;
        foreach (dn_vals[i]) begin
            cnt_in = 4'(dn_vals[i]);
            step();
        end
        pop_expect(8'h02);
        pop_expect(8'h01);
        pop_expect(8'h00);
        pop_expect(8'h3B);

        // Load with an unchanged value still records; a static value does not.
        cnt_in = 4'd7;
        step();
        cnt_load = 1'b1;
        step();
        cnt_load = 1'b0;
        repeat (3) step();
        check("load_level", 32'(level), 32'd2);
        pop_expect(8'h07);
        pop_expect(8'h17);

        // Ten changes with no reads: eight kept, two dropped.
        cnt_up_down = 1'b1;
        foreach (ov_vals[i]) begin
            cnt_in = 4'(ov_vals[i]);
            step();
        end
        check("ovf_full",  32'(full),     32'd1);
        check("ovf_level", 32'(level),    32'd8);
        check("ovf_flag",  32'(overflow), 32'd1);
        foreach (ov_exp[i]) pop_expect(ov_exp[i]);
        check("drain_empty",  32'(empty),    32'd1);
        check("drain_sticky", 32'(overflow), 32'd1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clear_ovf", 32'(overflow), 32'd0);

        // Refill to full, then push and pop together.
        cnt_in = 4'd5;
        step();
        step();
        foreach (fill_vals[i]) begin
            cnt_in = 4'(fill_vals[i]);
            step();
        end
        check("fill_full", 32'(full), 32'd1);
        cnt_in = 4'd1;
        rd_en  = 1'b1;
        step();
        rd_en = 1'b0;
        check("fullpp_level", 32'(level),    32'd8);
        check("fullpp_ovf",   32'(overflow), 32'd0);
        check("fullpp_data",  32'(rd_data),  32'h15);

        // Burst, then asynchronous reset between edges.
        for (int i = 0; i < 5; i++) begin
            cnt_in = 4'($urandom_range(0, MODULO - 1));
            rd_en  = 1'($urandom_range(0, 1));
            step();
        end
        rd_en = 1'b1;
        #2;
        resetn = 1'b0;
        #1;
        model_clear();
        check("arst_empty",    32'(empty),    32'd1);
        check("arst_level",    32'(level),    32'd0);
        check("arst_rd_valid", 32'(rd_valid), 32'd0);
        check("arst_rd_data",  32'(rd_data),  32'd0);
        rd_en = 1'b0;
        @(posedge clock);
        #1 resetn = 1'b1;

        // Randomized counter-like traffic.
        gc   = 0;
        gdir = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            cnt_load = 1'b0;
            r = int'($urandom_range(0, 9));
            if ($urandom_range(0, 7) == 0) gdir = ~gdir;
            if (gc >= MODULO) gc = 0;
            if (r < 4) begin
                gc = gdir ? (gc + 1) % MODULO : (gc + MODULO - 1) % MODULO;
            end else if (r == 4) begin
                cnt_load = 1'b1;
                gc = int'($urandom_range(0, MODULO - 1));
            end else if (r == 5) begin
                gc = int'($urandom_range(MODULO, 15));
            end
            cnt_in      = 4'(gc);
            cnt_up_down = gdir;
            cap_en      = ($urandom_range(0, 19) != 0);
            clear       = ($urandom_range(0, 59) == 0);
            if (i < 1500) rd_en = ($urandom_range(0, 2) == 0);
            else          rd_en = ($urandom_range(0, 2) != 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/count_capture_buf.md
Name: count_capture_buf

Overview:
- Downstream consumer of the mod-N loadable up/down counter.
- Watches the counter output and its load/direction controls every cycle.
- Records each value change as a tagged entry: normal step, load, wrap-up or wrap-down.
- Buffers entries in a small FIFO with a read handshake, so a host or checker can drain the count history without losing events.

Parameters:
- WIDTH, 4, counter data width.
- MODULO, 12, counter modulus; valid values are 0..MODULO-1.
- DEPTH, 8, FIFO entries; must be a power of 2.

Ports:
- clock  in  1  single clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- cnt_in  in  WIDTH  counter data_out.
- cnt_load  in  1  counter load control, same cycle as the cnt_in it produced.
- cnt_up_down  in  1  counter direction: 1 = up, 0 = down.
- cap_en  in  1  capture enable.
- clear  in  1  synchronous flush.
- rd_en  in  1  pop request.
- rd_data  out  WIDTH+2  {tag[1:0], value[WIDTH-1:0]}.
- rd_valid  out  1  rd_data valid, 1-cycle pulse.
- full  out  1  FIFO full.
- empty  out  1  FIFO empty.
- level  out  $clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky: an entry was dropped.

Behaviour:
- Reset (resetn low, asynchronous) and clear (synchronous, highest priority):
  - State goes to IDLE.
  - Pointers, level, prev, overflow, rd_data and rd_valid go to 0.
  - empty=1, full=0.
- FSM states and transitions:
  - IDLE: goes to PRIME when cap_en=1.
  - PRIME: latches prev<=cnt_in and pushes {TAG_LOAD, cnt_in} as the baseline entry, then goes to RUN.
  - RUN: returns to IDLE when cap_en=0; prev is held.
- Event detection in RUN, evaluated each cycle against prev:
  - Push condition: cnt_load=1, or cnt_in != prev.
  - Tag priority:
    - TAG_LOAD if cnt_load.
    - Else TAG_WRAP_UP if prev==MODULO-1 and cnt_in==0 and cnt_up_down=1.
    - Else TAG_WRAP_DN if prev==0 and cnt_in==MODULO-1 and cnt_up_down=0.
    - Else TAG_STEP.
  - prev<=cnt_in every RUN cycle.
  - cnt_in >= MODULO with no load: entry is pushed with TAG_STEP; no error flag is raised.
- Push/pop:
  - Push when not full: write at wr_ptr, then wr_ptr+1 with natural wrap.
  - Pop when rd_en=1 and not empty: rd_data<=mem[rd_ptr] registered, rd_valid=1 on the following cycle, rd_ptr+1.
  - rd_en while empty is ignored: rd_valid=0 and rd_data holds its last value.
  - Push and pop in the same cycle:
    - When full, both succeed and level is unchanged.
    - When empty, only the push succeeds; the pop is ignored.
  - Push while full with no pop: entry dropped, overflow<=1 and stays set until clear or reset.
- Flags:
  - level = registered occupancy, 0..DEPTH.
  - full = (level==DEPTH); empty = (level==0); both derived from registered level.
- Latency:
  - Event on cnt_in at edge k is visible in level at edge k+1.
  - Earliest readable with rd_en at k+1, giving rd_valid at k+2.
- Reset mid-operation: all state is discarded; the FSM restarts from IDLE and requires a new PRIME.

Decomposition:
- count_pkg additions:
  - tag typedef, 2-bit enum: TAG_STEP=2'b00, TAG_LOAD=2'b01, TAG_WRAP_UP=2'b10, TAG_WRAP_DN=2'b11.
  - FSM state enum: IDLE, PRIME, RUN.
  - Entry struct: {tag, value}.
- One natural sub-module: count_sync_fifo, a generic DEPTH x (WIDTH+2) synchronous FIFO that owns the pointers, level, full/empty and overflow.
- The top level holds the FSM, prev register and tag classification.

Test Plan:
- Reset, then cap_en=1 with cnt_in=5 -> one entry {LOAD,5}; level=1; rd_en gives rd_data=6'h15 and rd_valid one cycle later.
- RUN, up count 10,11,0,1 -> entries {STEP,10}, {STEP,11}, {WRAP_UP,0}, {STEP,1}, in that order.
- RUN, down count 1,0,11 -> {STEP,1}, {STEP,0}, {WRAP_DN,11}.
- cnt_load=1 with cnt_in unchanged at 7 -> {LOAD,7} is pushed; a static cnt_in=7 with no load pushes nothing.
- 10 distinct changes with no reads -> full=1, level=8, overflow=1; draining returns the first 8 entries in order, then empty=1 and overflow stays 1 until clear.
- While full, push and rd_en in the same cycle -> level stays 8, no overflow. Assert resetn=0 mid-burst -> empty=1, level=0 and rd_valid=0 immediately (asynchronous).
